aes192_request_scheduler: RTL and testbench

Sequencer and arbiter that shares one AES_Encryption_192 core between two requesters. It accepts one plaintext/key pair at a time under a valid/ready handshake, using round-robin priority. It drives the operands onto the core, holds them stable for a fixed core latency, captures the ciphertext and returns it to the owning requester. It sits between the requesters and the core's DATA / CIPHER_KEY / ENCRYPTED_DATA ports.

---
 rtl/aes192_request_scheduler_if.sv | 32 +++
 rtl/aes192_request_scheduler.sv | 111 +++++++++++
 tb/tb_aes192_request_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes192_request_scheduler_if.sv
// Requester, response and core-operand bundle for aes192_request_scheduler.
// master = requesters plus core result source; slave = the scheduler.
interface aes192_request_scheduler_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEY_W  = 192;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [0:DATA_W-1] req_data_0;
  logic [0:DATA_W-1] req_data_1;
  logic [0:KEY_W-1]  req_key_0;
  logic [0:KEY_W-1]  req_key_1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [0:DATA_W-1] rsp_data;
  logic [0:DATA_W-1] core_data;
  logic [0:KEY_W-1]  core_key;
  logic [0:DATA_W-1] core_result;
  logic              busy;

  modport master (
    output req_valid, req_data_0, req_data_1, req_key_0, req_key_1,
           rsp_ready, core_result,
    input  req_ready, rsp_valid, rsp_data, core_data, core_key, busy
  );

  modport slave (
    input  req_valid, req_data_0, req_data_1, req_key_0, req_key_1,
           rsp_ready, core_result,
    output req_ready, rsp_valid, rsp_data, core_data, core_key, busy
  );
endinterface

// File: rtl/aes192_request_scheduler.sv
// Round-robin sequencer sharing one AES-192 core between two requesters:
// accept, hold operands for CORE_LATENCY cycles, capture and return result.
module aes192_request_scheduler #(
  parameter int unsigned CORE_LATENCY = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  aes192_request_scheduler_if.slave     bus
);
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEY_W  = 192;
  localparam int unsigned CNT_W  = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [0:DATA_W-1] core_data_q, core_data_d;
  logic [0:KEY_W-1]  core_key_q, core_key_d;
  logic [0:DATA_W-1] rsp_data_q, rsp_data_d;

  logic              grant_c;
  logic              any_req_c;

  // Single requester wins outright; on contention the priority pointer decides.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant_c = prio_q;
    end else if (bus.req_valid[1]) begin
      grant_c = 1'b1;
    end
  end

  assign any_req_c = |bus.req_valid;

  assign bus.req_ready = (state_q == IDLE && !rst && any_req_c)
                         ? (grant_c ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.core_data = core_data_q;
  assign bus.core_key  = core_key_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          core_data_d = grant_c ? bus.req_data_1 : bus.req_data_0;
          core_key_d  = grant_c ? bus.req_key_1  : bus.req_key_0;
          owner_d     = grant_c;
          prio_d      = ~grant_c;
          cnt_d       = CNT_W'(CORE_LATENCY);
          state_d     = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Operands have been stable CORE_LATENCY cycles at this edge.
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = bus.core_result;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      core_data_q <= '0;
      core_key_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_aes192_request_scheduler.sv
// Directed bench for aes192_request_scheduler: one instance at latency 12,
// one at latency 1, each fed by a core model that is wrong until operands settle.
module tb_aes192_request_scheduler;
  localparam int unsigned LAT_A = 12;
  localparam int unsigned LAT_B = 1;

  localparam logic [0:127] KNOWN_D = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [0:191] KNOWN_K = 192'h000102030405060708090A0B0C0D0E0F1011121314151617;
  localparam logic [0:127] KNOWN_C = 128'hDDA97CA4864CDFE06EAF70A0EC0D7191;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes192_request_scheduler_if ifa ();
  aes192_request_scheduler_if ifb ();

  aes192_request_scheduler #(.CORE_LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  aes192_request_scheduler #(.CORE_LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_checks = 0;
  int n_errors = 0;

  // Reference cipher: the known AES-192 vector, otherwise an arbitrary mix.
  function automatic logic [0:127] aes_ref(input logic [0:127] d, input logic [0:191] k);
    logic [0:127] r;
    if (d == KNOWN_D && k == KNOWN_K) begin
      r = KNOWN_C;
    end else begin
      r = d ^ k[0:127] ^ {k[128:191], k[128:191]} ^ {d[64:127], d[0:63]};
    end
    return r;
  endfunction

  // Core output is only correct once the current operands have been present lat cycles.
  function automatic logic [0:127] core_out(input logic [0:127] d, input logic [0:191] k,
                                            input logic [0:127] pd, input logic [0:191] pk,
                                            input int run, input int lat);
    int c;
    c = (d == pd && k == pk) ? run + 1 : 1;
    return (c >= lat) ? aes_ref(d, k) : ~aes_ref(d, k);
  endfunction

  logic [0:127] pa_d = '0, pb_d = '0;
  logic [0:191] pa_k = '0, pb_k = '0;
  int run_a = 0, run_b = 0;

  always @(posedge clk) begin
    if (ifa.core_data != pa_d || ifa.core_key != pa_k) run_a <= 1;
    else if (run_a < 1000) run_a <= run_a + 1;
    pa_d <= ifa.core_data;
    pa_k <= ifa.core_key;
    if (ifb.core_data != pb_d || ifb.core_key != pb_k) run_b <= 1;
    else if (run_b < 1000) run_b <= run_b + 1;
    pb_d <= ifb.core_data;
    pb_k <= ifb.core_key;
  end

  assign ifa.core_result = core_out(ifa.core_data, ifa.core_key, pa_d, pa_k, run_a, LAT_A);
  assign ifb.core_result = core_out(ifb.core_data, ifb.core_key, pb_d, pb_k, run_b, LAT_B);

  // Accept monitor for instance A: edge index and granted requester.
  int   cyc = 0;
  int   acc_c[$];
  logic acc_g[$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (|(ifa.req_valid & ifa.req_ready)) begin
      acc_c.push_back(cyc);
      acc_g.push_back(ifa.req_ready[1]);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_a(output int n);
    n = 0;
    while (ifa.rsp_valid == 2'b00 && n < 64) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic [1:0] req_valid;
    logic [1:0] exp_ready;
  } grant_vec_t;

  typedef struct {
    logic         owner;
    logic [1:0]   exp_valid;
  } arb_vec_t;

  grant_vec_t gv[4];
  arb_vec_t   av[4];
  int         n;

  logic [0:127] d0, d1;
  logic [0:191] k0, k1;

  initial begin
    gv[0] = '{2'b00, 2'b00};
    gv[1] = '{2'b01, 2'b01};
    gv[2] = '{2'b10, 2'b10};
    gv[3] = '{2'b11, 2'b01};
    av[0] = '{1'b0, 2'b01};
    av[1] = '{1'b1, 2'b10};
    av[2] = '{1'b0, 2'b01};
    av[3] = '{1'b1, 2'b10};

    d0 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    k0 = 192'hA1A2A3A4A5A6A7A8B1B2B3B4B5B6B7B8C1C2C3C4C5C6C7C8;
    d1 = 128'hFEDCBA98765432100123456789ABCDEF;
    k1 = 192'h5555AAAA5555AAAA3333CCCC3333CCCC0F0FF0F00F0FF0F0;

    rst = 1'b1;
    ifa.req_valid = 2'b00; ifa.rsp_ready = 2'b00;
    ifa.req_data_0 = '0; ifa.req_data_1 = '0; ifa.req_key_0 = '0; ifa.req_key_1 = '0;
    ifb.req_valid = 2'b00; ifb.rsp_ready = 2'b00;
    ifb.req_data_0 = '0; ifb.req_data_1 = '0; ifb.req_key_0 = '0; ifb.req_key_1 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    ifa.req_valid = 2'b11;
    #1;
    check("rst_req_ready", 256'(ifa.req_ready), 256'(2'b00));
    check("rst_rsp_valid", 256'(ifa.rsp_valid), 256'(2'b00));
    check("rst_rsp_data", 256'(ifa.rsp_data), 256'd0);
    check("rst_core_data", 256'(ifa.core_data), 256'd0);
    check("rst_core_key", 256'(ifa.core_key), 256'd0);
    check("rst_busy", 256'(ifa.busy), 256'd0);
    check("rst_b_rsp_valid", 256'(ifb.rsp_valid), 256'(2'b00));
    ifa.req_valid = 2'b00;
    rst = 1'b0;

    // Combinational grant in IDLE with PRIO=0, no edge taken
    for (int i = 0; i < 4; i++) begin
      ifa.req_valid = gv[i].req_valid;
      #1;
      check($sformatf("grant_tbl_%0d", i), 256'(ifa.req_ready), 256'(gv[i].exp_ready));
    end
    ifa.req_valid = 2'b00;

    // Single op with the known vector
    ifa.req_data_0 = KNOWN_D; ifa.req_key_0 = KNOWN_K;
    ifa.req_valid = 2'b01; ifa.rsp_ready = 2'b01;
    step();
    ifa.req_valid = 2'b00;
    check("single_busy", 256'(ifa.busy), 256'd1);
    check("single_core_data", 256'(ifa.core_data), 256'(KNOWN_D));
    check("single_core_key", 256'(ifa.core_key), 256'(KNOWN_K));
    wait_rsp_a(n);
    check("single_latency", 256'(n), 256'(LAT_A));
    check("single_rsp_valid", 256'(ifa.rsp_valid), 256'(2'b01));
    check("single_rsp_data", 256'(ifa.rsp_data), 256'(KNOWN_C));
    step();
    check("single_done_valid", 256'(ifa.rsp_valid), 256'(2'b00));
    check("single_done_busy", 256'(ifa.busy), 256'd0);

    // Arbitration from reset: both valid, ready held high
    rst = 1'b1;
    ifa.req_data_0 = d0; ifa.req_key_0 = k0;
    ifa.req_data_1 = d1; ifa.req_key_1 = k1;
    ifa.req_valid = 2'b11; ifa.rsp_ready = 2'b11;
    step();
    check("rst_core_data_cleared", 256'(ifa.core_data), 256'd0);
    acc_c.delete(); acc_g.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp_a(n);
      check($sformatf("arb_lat_%0d", i), 256'(n), 256'(LAT_A + 1));
      check($sformatf("arb_valid_%0d", i), 256'(ifa.rsp_valid), 256'(av[i].exp_valid));
      check($sformatf("arb_data_%0d", i), 256'(ifa.rsp_data),
            256'(av[i].owner ? aes_ref(d1, k1) : aes_ref(d0, k0)));
      if (i == 3) ifa.req_valid = 2'b00;
      step();
    end
    check("arb_accepts", 256'(acc_g.size()), 256'd4);
    if (acc_g.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("arb_grant_%0d", i), 256'(acc_g[i]), 256'(av[i].owner));
        if (i > 0) check($sformatf("arb_spacing_%0d", i), 256'(acc_c[i] - acc_c[i-1]),
                         256'(LAT_A + 2));
      end
    end

    // Backpressure on requester 0, requester 1 waiting
    acc_c.delete(); acc_g.delete();
    ifa.req_valid = 2'b01; ifa.rsp_ready = 2'b00;
    step();
    ifa.req_valid = 2'b10;
    check("bp_run_ready", 256'(ifa.req_ready), 256'(2'b00));
    wait_rsp_a(n);
    check("bp_latency", 256'(n), 256'(LAT_A));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_valid_%0d", i), 256'(ifa.rsp_valid), 256'(2'b01));
      check($sformatf("bp_data_%0d", i), 256'(ifa.rsp_data), 256'(aes_ref(d0, k0)));
      check($sformatf("bp_ready_%0d", i), 256'(ifa.req_ready), 256'(2'b00));
      if (i < 7) step();
    end
    ifa.rsp_ready = 2'b01;
    step();
    check("bp_complete", 256'(ifa.rsp_valid), 256'(2'b00));
    check("bp_no_accept_same_edge", 256'(acc_g.size()), 256'd1);
    step();
    check("bp_next_accept", 256'(acc_g.size()), 256'd2);
    if (acc_g.size() >= 2) check("bp_next_grant", 256'(acc_g[1]), 256'd1);

    // Wrong-owner ready: owner 1, only bit 0 of RSP_READY high
    ifa.req_valid = 2'b00; ifa.rsp_ready = 2'b01;
    wait_rsp_a(n);
    check("wo_latency", 256'(n), 256'(LAT_A));
    check("wo_data", 256'(ifa.rsp_data), 256'(aes_ref(d1, k1)));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wo_hold_%0d", i), 256'(ifa.rsp_valid), 256'(2'b10));
      step();
    end
    ifa.rsp_ready = 2'b10;
    step();
    check("wo_complete", 256'(ifa.rsp_valid), 256'(2'b00));
    check("wo_idle", 256'(ifa.busy), 256'd0);

    // Reset three cycles into RUN
    ifa.req_valid = 2'b01; ifa.rsp_ready = 2'b01;
    step();
    ifa.req_valid = 2'b00;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 256'(ifa.busy), 256'd0);
    check("mid_rst_rsp_valid", 256'(ifa.rsp_valid), 256'(2'b00));
    check("mid_rst_rsp_data", 256'(ifa.rsp_data), 256'd0);
    check("mid_rst_core_data", 256'(ifa.core_data), 256'd0);
    check("mid_rst_core_key", 256'(ifa.core_key), 256'd0);
    step();
    step();
    check("mid_rst_no_rsp", 256'(ifa.rsp_valid), 256'(2'b00));
    ifa.req_data_0 = KNOWN_D; ifa.req_key_0 = KNOWN_K;
    ifa.req_valid = 2'b11;
    acc_c.delete(); acc_g.delete();
    rst = 1'b0;
    step();
    ifa.req_valid = 2'b00;
    check("post_rst_accepts", 256'(acc_g.size()), 256'd1);
    if (acc_g.size() >= 1) check("post_rst_grant", 256'(acc_g[0]), 256'd0);
    wait_rsp_a(n);
    check("post_rst_latency", 256'(n), 256'(LAT_A));
    check("post_rst_valid", 256'(ifa.rsp_valid), 256'(2'b01));
    check("post_rst_data", 256'(ifa.rsp_data), 256'(KNOWN_C));
    step();
    check("post_rst_done", 256'(ifa.rsp_valid), 256'(2'b00));

    // CORE_LATENCY = 1 instance
    ifb.req_data_1 = d1; ifb.req_key_1 = k1;
    ifb.req_valid = 2'b10; ifb.rsp_ready = 2'b10;
    step();
    ifb.req_valid = 2'b00;
    check("lat1_run_valid", 256'(ifb.rsp_valid), 256'(2'b00));
    check("lat1_run_busy", 256'(ifb.busy), 256'd1);
    step();
    check("lat1_rsp_valid", 256'(ifb.rsp_valid), 256'(2'b10));
    check("lat1_rsp_data", 256'(ifb.rsp_data), 256'(aes_ref(d1, k1)));
    step();
    check("lat1_done", 256'(ifb.rsp_valid), 256'(2'b00));
    check("lat1_idle", 256'(ifb.busy), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
